// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for a 32-point FFT: loads a frame, issues butterflies, drains the pipe.
// Latency: outputs are registered (except bf_en); out_valid follows bf_en by LAT cycles.
// Backpressure: in_valid/in_ready handshake in LOAD; out_ready=0 freezes issue in PROC.
//
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   start                 frame request, honoured only in IDLE
//   in_valid / in_ready   load handshake; load_addr is the write address of the accepted sample
//   out_ready             downstream ready; gates bf_en during PROC
//   rd_addr, sel          buffer read address and twiddle group for the current issue
//   bf_en, out_valid      butterfly issue strobe and its LAT-delayed result strobe
//   busy, done            not-idle flag and one-cycle end-of-frame pulse
module fft_frame_sequencer #(
    parameter int N_PTS = 32,
    parameter int LAT   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [4:0] load_addr,
    input  logic       out_ready,
    output logic [4:0] rd_addr,
    output logic [2:0] sel,
    output logic       bf_en,
    output logic       out_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PROC  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [4:0] LAST_PT    = 5'(N_PTS - 1);
    localparam logic [2:0] LAST_DRAIN = 3'(LAT - 1);

    state_t           state;
    state_t           nxt_state;
    logic [4:0]       lcnt;
    logic [4:0]       nxt_lcnt;
    logic [4:0]       pcnt;
    logic [4:0]       nxt_pcnt;
    logic [2:0]       dcnt;
    logic [2:0]       nxt_dcnt;
    logic [LAT-1:0]   vld_sr;

    // The only output allowed to see an input combinationally.
    assign bf_en     = (state == PROC) && out_ready;
    assign out_valid = vld_sr[LAT-1];

    always_comb begin
        nxt_state = state;
        nxt_lcnt  = lcnt;
        nxt_pcnt  = pcnt;
        nxt_dcnt  = dcnt;
        case (state)
            IDLE: begin
                if (start) begin
                    nxt_state = LOAD;
                    nxt_lcnt  = 5'd0;
                end
            end
            LOAD: begin
                if (in_valid && in_ready) begin
                    if (lcnt == LAST_PT) begin
                        nxt_state = PROC;
                        nxt_lcnt  = 5'd0;
                        nxt_pcnt  = 5'd0;
                    end else begin
                        nxt_lcnt = lcnt + 5'd1;
                    end
                end
            end
            PROC: begin
                if (bf_en) begin
                    if (pcnt == LAST_PT) begin
                        nxt_state = DRAIN;
                        nxt_pcnt  = 5'd0;
                        nxt_dcnt  = 3'd0;
                    end else begin
                        nxt_pcnt = pcnt + 5'd1;
                    end
                end
            end
            DRAIN: begin
                // LAT cycles here so the last issued butterfly reaches out_valid
                // in the final DRAIN cycle.
                if (dcnt == LAST_DRAIN) begin
                    nxt_state = DONE;
                    nxt_dcnt  = 3'd0;
                end else begin
                    nxt_dcnt = dcnt + 3'd1;
                end
            end
            DONE: begin
                nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with the
    // state they describe, without any combinational path from the inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            lcnt      <= 5'd0;
            pcnt      <= 5'd0;
            dcnt      <= 3'd0;
            vld_sr    <= '0;
            in_ready  <= 1'b0;
            load_addr <= 5'd0;
            rd_addr   <= 5'd0;
            sel       <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt_state;
            lcnt      <= nxt_lcnt;
            pcnt      <= nxt_pcnt;
            dcnt      <= nxt_dcnt;
            in_ready  <= (nxt_state == LOAD);
            load_addr <= (nxt_state == LOAD) ? nxt_lcnt : 5'd0;
            rd_addr   <= (nxt_state == PROC) ? nxt_pcnt : 5'd0;
            sel       <= (nxt_state == PROC) ? nxt_pcnt[4:2] : 3'd0;
            busy      <= (nxt_state != IDLE);
            done      <= (nxt_state == DONE);
            // Free-running shift: stall bubbles appear as out_valid gaps.
            vld_sr[0] <= bf_en;
            for (int i = 1; i < LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Testbench for fft_frame_sequencer: records one frame of per-cycle activity and
// judges it against the frame-level rules (handshake order, issue order, delayed
// valids, done timing), plus directed reset scenarios.
module tb_fft_frame_sequencer;

    localparam int LAT   = 3;
    localparam int NP    = 32;
    localparam int DEPTH = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic [4:0] load_addr;
    logic [4:0] rd_addr;
    logic [2:0] sel;
    logic       bf_en;
    logic       out_valid;
    logic       busy;
    logic       done;

    fft_frame_sequencer #(.N_PTS(NP), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .load_addr (load_addr),
        .out_ready (out_ready),
        .rd_addr   (rd_addr),
        .sel       (sel),
        .bf_en     (bf_en),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    logic tr_iv   [DEPTH];
    logic tr_or   [DEPTH];
    logic tr_ir   [DEPTH];
    logic tr_bf   [DEPTH];
    logic tr_ov   [DEPTH];
    logic tr_busy [DEPTH];
    logic tr_done [DEPTH];
    int   tr_la   [DEPTH];
    int   tr_ra   [DEPTH];
    int   tr_sel  [DEPTH];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int outs_word();
        int w;
        w = 0;
        w[17:0] = {in_ready, load_addr, rd_addr, sel, bf_en, out_valid, busy, done};
        return w;
    endfunction

    // One clock: drive just after the rising edge, sample at the falling edge.
    task automatic step(input logic s, input logic iv, input logic ordy, input logic rn);
        @(posedge clk);
        #1;
        start     = s;
        in_valid  = iv;
        out_ready = ordy;
        rst_n     = rn;
        @(negedge clk);
        if (cyc < DEPTH) begin
            tr_iv[cyc]   = iv;
            tr_or[cyc]   = ordy;
            tr_ir[cyc]   = in_ready;
            tr_bf[cyc]   = bf_en;
            tr_ov[cyc]   = out_valid;
            tr_busy[cyc] = busy;
            tr_done[cyc] = done;
            tr_la[cyc]   = int'(load_addr);
            tr_ra[cyc]   = int'(rd_addr);
            tr_sel[cyc]  = int'(sel);
        end
        cyc++;
    endtask

    // Frame-level judgement of trace cycles 0..cyc-1; cycle 0 is the start cycle.
    task automatic analyse(input string name, input bit gapped);
        int n, hs, lh, iss, li, ovc, lastov, dc, dcy;
        int hsb, isb, le, pe, oe, be, exp_ov, exp_busy;
        bit in_load, in_proc;
        n = (cyc < DEPTH) ? cyc : DEPTH;
        hs = 0; lh = -1; iss = 0; li = -1; ovc = 0; lastov = -1; dc = 0; dcy = -1;
        for (int c = 0; c < n; c++) begin
            if (tr_iv[c] && tr_ir[c]) begin hs++; lh = c; end
            if (tr_bf[c]) begin iss++; li = c; end
            if (tr_ov[c]) begin ovc++; lastov = c; end
            if (tr_done[c]) begin dc++; dcy = c; end
        end
        hsb = 0; isb = 0; le = 0; pe = 0; oe = 0; be = 0;
        for (int c = 0; c < n; c++) begin
            in_load = (c >= 1) && (c <= lh);
            in_proc = (c > lh) && (c <= li);
            if (in_load) begin
                if (!tr_ir[c] || tr_la[c] != hsb) le++;
            end else begin
                if (tr_ir[c] || tr_la[c] != 0) le++;
            end
            // In PROC the read address is the number of points already issued.
            if (in_proc) begin
                if (tr_bf[c] != tr_or[c] || tr_ra[c] != isb || tr_sel[c] != isb / 4) pe++;
            end else begin
                if (tr_bf[c] || tr_ra[c] != 0 || tr_sel[c] != 0) pe++;
            end
            exp_ov = (c >= LAT) ? int'(tr_bf[c-LAT]) : 0;
            if (int'(tr_ov[c]) != exp_ov) oe++;
            exp_busy = ((c >= 1) && (c <= dcy)) ? 1 : 0;
            if (int'(tr_busy[c]) != exp_busy) be++;
            if (tr_iv[c] && tr_ir[c]) hsb++;
            if (tr_bf[c]) isb++;
        end
        check_eq({name, "/handshakes"}, hs, NP);
        check_eq({name, "/load_errs"}, le, 0);
        check_eq({name, "/issues"}, iss, NP);
        check_eq({name, "/proc_errs"}, pe, 0);
        check_eq({name, "/out_valid_errs"}, oe, 0);
        check_eq({name, "/out_valid_cnt"}, ovc, NP);
        check_eq({name, "/last_out_valid"}, lastov, li + LAT);
        check_eq({name, "/done_cnt"}, dc, 1);
        check_eq({name, "/done_cycle"}, dcy, li + LAT + 1);
        check_eq({name, "/busy_errs"}, be, 0);
        if (gapped) check_eq({name, "/last_handshake"}, lh, 63);
    endtask

    // vmode: 0 in_valid always, 1 alternating 1/0, 2 random; rmode: 0 ready always, 1 random.
    task automatic run_frame(input int vmode, input int rmode, input bit stall10,
                             input bit noisy, input string name);
        int  iss, li, stall_rem, stall_bad;
        bit  s, iv, ordy;
        iss = 0; li = -1; stall_rem = stall10 ? 5 : 0; stall_bad = 0;
        cyc = 0;
        step(1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k < 900; k++) begin
            if (vmode == 0)      iv = 1'b1;
            else if (vmode == 1) iv = (k % 2 == 1);
            else                 iv = ($urandom_range(0, 9) < 7);
            ordy = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (stall_rem > 0 && iss == 10) begin
                ordy = 1'b0;
                stall_rem--;
            end
            s = noisy && ($urandom_range(0, 4) == 0);
            if (noisy && li >= 0 && k == li + LAT + 1) s = 1'b1;
            step(s, iv, ordy, 1'b1);
            if (stall10 && iss == 10 && !ordy) begin
                if (rd_addr != 5'd10 || sel != 3'd2 || bf_en) stall_bad++;
            end
            if (tr_bf[k]) begin
                iss++;
                if (iss == NP) li = k;
            end
            if (tr_done[k]) break;
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        analyse(name, vmode == 1);
        if (stall10) check_eq({name, "/stall_hold_errs"}, stall_bad, 0);
    endtask

    initial begin
        int iss, bad;

        // Power-on reset.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("reset/outputs", outs_word(), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("reset/idle_outputs", outs_word(), 0);

        run_frame(0, 0, 1'b0, 1'b0, "nominal");
        run_frame(1, 0, 1'b0, 1'b0, "gapped");
        run_frame(0, 0, 1'b1, 1'b0, "stall");
        run_frame(0, 0, 1'b0, 1'b1, "ignored_start");
        for (int f = 0; f < 4; f++) run_frame(2, 1, 1'b0, 1'b1, "random");

        // Reset in the middle of PROC once 20 points have been issued.
        cyc = 0;
        iss = 0;
        step(1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k < 200; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1);
            if (tr_bf[k]) iss++;
            if (iss == 20) break;
        end
        check_eq("rst_proc/rd_addr_before", int'(rd_addr), 19);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("rst_proc/outputs_in_reset", outs_word(), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_proc/outputs_after", outs_word(), 0);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            if (done || busy || out_valid) bad++;
        end
        check_eq("rst_proc/no_done", bad, 0);
        run_frame(0, 0, 1'b0, 1'b0, "after_proc_reset");

        // Reset in the middle of LOAD; the next frame must load from address 0.
        cyc = 0;
        step(1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_load/outputs_after", outs_word(), 0);
        run_frame(1, 1, 1'b0, 1'b0, "after_load_reset");

        // Reset and start in the same cycle: reset wins.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_start/busy", int'(busy), 0);
        check_eq("rst_start/outputs", outs_word(), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_start/busy_later", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
